// File: rtl/ram_responder.sv
// Backing-store responder for a cache miss/write-back port: serves single-word
// writes and aligned block reads from a word array with a fixed response latency.
module ram_responder #(
    parameter int RAM_ADDRESS_BITS = 32,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int MEM_ADDRESS_BITS = 12,
    parameter int LATENCY          = 3
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [RAM_ADDRESS_BITS-1:0]                prop_address,
    input  logic                                       prop_read_en,
    input  logic [DATA_BITS-1:0]                       prop_write_data,
    input  logic                                       prop_write_en,
    output logic                                       ram_valid,
    output logic [(2**BLOCK_BITS)-1:0][DATA_BITS-1:0]  ram_data,
    output logic                                       busy,
    output logic [1:0]                                 state_dbg
);

    localparam int WORDS = 2 ** BLOCK_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                                state;
    logic [7:0]                            count;
    logic                                  op_write;
    logic [MEM_ADDRESS_BITS-1:0]           base_q;
    logic [MEM_ADDRESS_BITS-1:0]           mem_index;
    logic [MEM_ADDRESS_BITS-1:0]           block_base;
    logic                                  accept;
    logic [WORDS-1:0][DATA_BITS-1:0]       resp_block;
    logic [DATA_BITS-1:0]                  mem [2**MEM_ADDRESS_BITS] = '{default: '0};

    // Handshake: prop_*_en are levels held by the cache; a request is taken on
    // any rising edge seen in IDLE, and answered by exactly one ram_valid pulse.
    assign mem_index  = prop_address[MEM_ADDRESS_BITS-1:0];
    assign block_base = mem_index & ~(MEM_ADDRESS_BITS'(WORDS - 1));
    assign accept     = (state == IDLE) && (prop_read_en || prop_write_en);
    assign state_dbg  = state;

    always_comb begin
        resp_block = '0;
        for (int i = 0; i < WORDS; i++) begin
            resp_block[i] = mem[base_q + MEM_ADDRESS_BITS'(i)];
        end
    end

    // Memory is written at the acceptance edge so later reads see the new word
    // even while this write's response is still pending.
    always_ff @(posedge clk) begin
        if (reset_n && (state == IDLE) && prop_write_en) begin
            mem[mem_index] <= prop_write_data;
        end
    end

    // RESP is the cycle in which the response is registered; ram_valid is
    // visible in the cycle after it, when the FSM is already back in IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            op_write  <= 1'b0;
            base_q    <= '0;
            ram_valid <= 1'b0;
            ram_data  <= '0;
            busy      <= 1'b0;
        end else begin
            ram_valid <= 1'b0;
            ram_data  <= '0;
            busy      <= accept || (state != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write <= prop_write_en;
                        base_q   <= block_base;
                        count    <= 8'(LATENCY - 1);
                        state    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (count <= 8'd1) begin
                        state <= RESP;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                RESP: begin
                    ram_valid <= 1'b1;
                    if (!op_write) begin
                        ram_data <= resp_block;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a default instance (LATENCY=3, 4-word blocks) and a
// small one (LATENCY=1, 2-word blocks) checked against a word-array model.
module tb_ram_responder;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;
    logic         sel = 1'b0;

    logic               valid0, valid1, busy0, busy1;
    logic [3:0][31:0]   data0;
    logic [1:0][31:0]   data1;
    logic [1:0]         st0, st1;

    logic               obs_valid, obs_busy;
    logic [127:0]       obs_data;

    int checks = 0;
    int errors = 0;

    logic [31:0]  mm [2][4096];
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    ram_responder dut0 (
        .clk(clk), .reset_n(reset_n), .prop_address(addr),
        .prop_read_en(rd & ~sel), .prop_write_data(wdata), .prop_write_en(wr & ~sel),
        .ram_valid(valid0), .ram_data(data0), .busy(busy0), .state_dbg(st0)
    );

    ram_responder #(.LATENCY(1), .BLOCK_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .prop_address(addr),
        .prop_read_en(rd & sel), .prop_write_data(wdata), .prop_write_en(wr & sel),
        .ram_valid(valid1), .ram_data(data1), .busy(busy1), .state_dbg(st1)
    );

    assign obs_valid = sel ? valid1 : valid0;
    assign obs_busy  = sel ? busy1 : busy0;
    assign obs_data  = sel ? {64'b0, data1} : data0;

    function automatic int lat();
        return sel ? 1 : 3;
    endfunction

    // Model side of an acceptance: update the word array, queue the response.
    task automatic accept_model(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
        int idx, words, base;
        logic [127:0] blk;
        idx   = int'(a % 32'd4096);
        words = sel ? 2 : 4;
        base  = idx - (idx % words);
        blk   = '0;
        if (is_wr) begin
            mm[sel][idx] = d;
        end else begin
            for (int i = 0; i < words; i++) blk[i*32 +: 32] = mm[sel][(base + i) % 4096];
        end
        exp_q.push_back(blk);
    endtask

    // Called just after an acceptance edge; returns at the negedge of the ram_valid cycle.
    task automatic wait_valid(input string name);
        int waited = 0;
        logic [127:0] e;
        @(negedge clk);
        while (obs_valid !== 1'b1 && waited < 40) begin
            checks++;
            if (obs_busy !== 1'b1) begin
                errors++; $display("FAIL %s busy_pending got %b want 1", name, obs_busy);
            end
            checks++;
            if (obs_data !== '0) begin
                errors++; $display("FAIL %s data_idle got %h want 0", name, obs_data);
            end
            waited++;
            @(negedge clk);
        end
        checks++;
        if (waited != lat()) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, waited, lat());
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (obs_valid === 1'b1) begin
            checks++;
            if (obs_data !== e) begin
                errors++; $display("FAIL %s data got %h want %h", name, obs_data, e);
            end
            checks++;
            if (obs_busy !== 1'b1) begin
                errors++; $display("FAIL %s busy_resp got %b want 1", name, obs_busy);
            end
        end
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic single_req(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                              input string name);
        addr = a; wdata = d; wr = is_wr; rd = ~is_wr;
        @(posedge clk);
        accept_model(is_wr, a, d);
        wait_valid(name);
        wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after got valid=%b busy=%b want 0 0", name, obs_valid, obs_busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rd = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid0, busy0, valid1, busy1} !== 4'b0) begin
            errors++; $display("FAIL reset flags got %b want 0000", {valid0, busy0, valid1, busy1});
        end
        checks++;
        if (data0 !== '0 || data1 !== '0) begin
            errors++; $display("FAIL reset data got %h %h want 0", data0, data1);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_zero();
        sel = 1'b0;
        single_req(1'b0, 32'h0, 32'h0, "read_zero");
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        single_req(1'b1, 32'h10002, 32'haaaa, "wr_aaaa");
        addr = 32'h10001; rd = 1'b1;
        @(posedge clk);
        accept_model(1'b0, 32'h10001, 32'h0);
        wait_valid("rd_alias");
        rd = 1'b0;
        checks++;
        if (obs_data[95:64] !== 32'haaaa || obs_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL rd_alias words got %h want word2=aaaa", obs_data);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        sel = 1'b0;
        addr = 32'h5; wdata = 32'h77; wr = 1'b1; rd = 1'b1;
        @(posedge clk);
        accept_model(1'b1, 32'h5, 32'h77);
        wait_valid("prio_write");
        wr = 1'b0;
        @(posedge clk);
        accept_model(1'b0, 32'h5, 32'h0);
        wait_valid("prio_read");
        rd = 1'b0;
        checks++;
        if (obs_data[63:32] !== 32'h77) begin
            errors++; $display("FAIL prio_word1 got %h want 00000077", obs_data[63:32]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        addr = 32'h4; rd = 1'b1;
        @(posedge clk);
        accept_model(1'b0, 32'h4, 32'h0);
        wait_valid("b2b_first");
        @(posedge clk);
        accept_model(1'b0, 32'h4, 32'h0);
        wait_valid("b2b_second");
        rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_extra_pulse got %b want 0 at %0d", obs_valid, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        addr = 32'h8; wdata = 32'h1234; wr = 1'b1;
        @(posedge clk);
        accept_model(1'b1, 32'h8, 32'h1234);
        exp_q.delete();
        @(negedge clk);
        wr = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid busy got %b want 0", obs_busy);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++; $display("FAIL reset_mid valid got %b want 0 at %0d", obs_valid, i);
            end
            @(negedge clk);
        end
        addr = 32'h8; rd = 1'b1;
        @(posedge clk);
        accept_model(1'b0, 32'h8, 32'h0);
        wait_valid("reset_mid_read");
        rd = 1'b0;
        checks++;
        if (obs_data[31:0] !== 32'h1234) begin
            errors++; $display("FAIL reset_mid_word0 got %h want 00001234", obs_data[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_small();
        logic [31:0] v6, v7;
        sel = 1'b1;
        v6 = $urandom; v7 = $urandom;
        single_req(1'b1, 32'h6, v6, "small_wr6");
        single_req(1'b1, 32'h7, v7, "small_wr7");
        addr = 32'h7; rd = 1'b1;
        @(posedge clk);
        accept_model(1'b0, 32'h7, 32'h0);
        wait_valid("small_rd7");
        rd = 1'b0;
        checks++;
        if (obs_data[63:0] !== {v7, v6}) begin
            errors++; $display("FAIL small_block got %h want %h", obs_data[63:0], {v7, v6});
        end
        @(negedge clk);
    endtask

    task automatic test_random(input bit s);
        sel = s;
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 31));
            single_req(1'($urandom_range(0, 1)), a, $urandom, s ? "rand_small" : "rand_dflt");
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mm[0][i] = '0;
            mm[1][i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_read_zero();
        test_write_read();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_small();
        test_random(1'b0);
        test_random(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder that sits at the far end of the cache's miss/write-back interface.
- Accepts the cache's prop_address / prop_read_en / prop_write_en / prop_write_data requests and services them from an internal word-addressed array.
- Answers every request with a one-cycle ram_valid pulse after a fixed LATENCY; for reads, the pulse carries the full aligned block on ram_data.
- Serves as the RAM stand-in for cache benches and as the reference backing-store model.

Parameters:
RAM_ADDRESS_BITS, 32, width of prop_address (word address)
DATA_BITS, 32, word width
BLOCK_BITS, 2, log2 of words per cache block; ram_data carries 2**BLOCK_BITS words
MEM_ADDRESS_BITS, 12, log2 of backing-array depth in words; upper address bits ignored (aliasing)
LATENCY, 3, cycles from request acceptance to ram_valid; legal range 1..255

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
prop_address  in  RAM_ADDRESS_BITS  request word address
prop_read_en  in  1  block-read request (level, held by cache until served)
prop_write_data  in  DATA_BITS  single-word write data
prop_write_en  in  1  single-word write request (level)
ram_valid  out  1  one-cycle response strobe
ram_data  out  (2**BLOCK_BITS) x DATA_BITS  block read data; element i = word (aligned base + i)
busy  out  1  high from the acceptance edge until the ram_valid cycle ends

Behaviour:
- Reset (reset_n low at a rising edge):
  - State goes to IDLE; the latency counter clears.
  - ram_valid=0, ram_data all zero, busy=0.
  - Memory array contents are NOT touched by reset; the array is zero-initialised at elaboration.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Samples requests at each rising edge.
  - If prop_write_en=1, accept the write. Write has priority when both enables are high; the held read is accepted later from IDLE.
  - Otherwise, if prop_read_en=1, accept the read.
  - At acceptance, latch the op type and block base = prop_address with the low BLOCK_BITS bits cleared, set busy=1, and load counter=LATENCY-1.
  - Next state is RESP if LATENCY=1, else WAIT.
- Write acceptance:
  - mem[prop_address[MEM_ADDRESS_BITS-1:0]] <= prop_write_data at the acceptance edge itself (full word address, not block-aligned).
- WAIT:
  - Decrement counter each edge; go to RESP when the counter reaches 1.
  - Input changes are ignored; an accepted request is committed even if its enable drops.
- RESP (exactly one cycle): ram_valid=1, busy=1.
  - Read: ram_data[i] = mem[base+i] for i in 0..2**BLOCK_BITS-1, with index arithmetic modulo 2**MEM_ADDRESS_BITS.
  - Write: ram_data all zero.
  - Next state is IDLE.
- ram_data equals zero in every cycle where ram_valid=0.
- Timing: a request accepted at edge k gives ram_valid high for exactly the cycle following edge k+LATENCY.
- Back-to-back requests:
  - IDLE is entered after RESP. A request still asserted in the first IDLE cycle is accepted as a new request at the next edge.
  - Minimum spacing between ram_valid pulses is LATENCY+1 cycles.
  - The cache must drop its enable during the ram_valid cycle to avoid a duplicate service.
- Read-after-write to the same word returns the new data, because memory is updated at write acceptance.
- Reset mid-operation (WAIT or RESP):
  - The pending response is aborted; no ram_valid is produced.
  - A write already accepted remains in memory.
- Address wrap: bits above MEM_ADDRESS_BITS are ignored, e.g. 'h10000 and 'h00000 alias with the default 12 bits.

Test Plan:
- Reset, then read at prop_address='h0 -> busy rises at the acceptance edge; ram_valid high exactly 3 cycles after acceptance for one cycle; ram_data = {0,0,0,0}; ram_valid=0 and ram_data=0 in all other cycles.
- Write 'haaaa @ 'h10002 (LATENCY=3), drop enable on ram_valid, then read 'h10001 -> write ram_valid after 3 cycles with ram_data=0; read returns {0,0,'haaaa,0}.
- prop_read_en=1 and prop_write_en=1 both held with address 'h5 and data 'h77 -> write served first; read is accepted at the edge after the write's RESP cycle; read ram_data[1]='h77.
- Read held high through ram_valid -> a second ram_valid occurs exactly LATENCY+1 cycles after the first; enable dropped in the ram_valid cycle -> only one pulse.
- reset_n low for one cycle while in WAIT after write 'h1234 @ 'h8 -> no ram_valid; busy=0 after reset; subsequent read of 'h8 returns ram_data[0]='h1234.
- Rerun with LATENCY=1 and BLOCK_BITS=1 -> ram_valid on the cycle right after acceptance; ram_data has 2 words, base aligned to even address ('h7 returns words 'h6,'h7).
